// File: rtl/mac_accum_pkg.sv
// Shared types, defaults and helpers for the product accumulator slice.
package mac_accum_pkg;

  localparam int DEF_PROD_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 10;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Valid-bit delay line: re-aligns an issue-side valid with a pipeline that
// produces its result DEPTH cycles later. DEPTH = 0 is a plain wire.
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst;
      assign q = d;
    end else if (DEPTH == 1) begin : g_one
      logic sr_q;
      // Single-stage delay with synchronous clear.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= 1'b0;
        else     sr_q <= d;
      end
      assign q = sr_q;
    end else begin : g_many
      logic [DEPTH-1:0] sr_q;
      // Shift towards the MSB; the MSB is the oldest sample.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= {sr_q[DEPTH-2:0], d};
      end
      assign q = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mac_accum.sv
// Accumulates groups of COUNT multiplier products and presents each finished
// sum on a single-entry valid/ready output register.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int COUNT      = 4,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int IN_LATENCY = 3,
  parameter int CNT_WIDTH  = clog2(COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PROD_WIDTH-1:0] q,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  busy,
  output logic                  overrun
);

  // The delay line has no "any bit set" port, so the number of valid beats
  // in flight is tracked here; it never exceeds IN_LATENCY.
  localparam int FL_WIDTH = clog2(IN_LATENCY + 2);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(COUNT - 1);

  logic                  beat;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum, comp_sum;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc, comp_cnt;
  logic [FL_WIDTH-1:0]   inflight_q, inflight_d;
  logic                  complete;
  out_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovr_q, ovr_d;

  valid_delay #(
    .DEPTH (IN_LATENCY)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d   (in_valid),
    .q   (beat)
  );

  // Group accumulation and completion detect (COUNT-th beat or flush).
  always_comb begin
    acc_sum    = acc_q + ACC_WIDTH'(q);
    cnt_inc    = cnt_q + CNT_WIDTH'(1);
    inflight_d = inflight_q + FL_WIDTH'(in_valid) - FL_WIDTH'(beat);
    complete   = (beat && (cnt_q == LAST_CNT)) ||
                 (flush && (beat || (cnt_q != '0)));
    comp_sum   = beat ? acc_sum : acc_q;
    comp_cnt   = beat ? cnt_inc : cnt_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      acc_d = acc_sum;
      cnt_d = cnt_inc;
    end
  end

  // Output register: load on completion, drain on ready, drop when blocked.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          state_d = OUT_FULL;
          sum_d   = comp_sum;
          count_d = comp_cnt;
        end
      end
      OUT_FULL: begin
        if (out_ready) begin
          if (complete) begin
            sum_d   = comp_sum;
            count_d = comp_cnt;
          end else begin
            state_d = OUT_EMPTY;
          end
        end else if (complete) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
      state_q    <= OUT_EMPTY;
      sum_q      <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign overrun   = ovr_q;
  assign busy      = (cnt_q != '0) || (inflight_q != '0);

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Downstream consumer of the pipelined 4x4 multiplier stage.
- Takes the 8-bit product stream q, accumulates COUNT products per group and presents each completed sum on a valid/ready output register.
- The multiplier has no valid signal, so this block carries a valid delay line. The line re-aligns the issue-side valid with the product emerging IN_LATENCY cycles later.
- Sits between the multiplier output and any result sink (bus slave, FIFO, UART framer).

Parameters:
- PROD_WIDTH, 8: product width (matches multiplier output q).
- COUNT, 4: products per accumulated group; must be >= 1.
- ACC_WIDTH, 10: accumulator/sum width; must be >= PROD_WIDTH + clog2(COUNT), so no overflow is possible.
- IN_LATENCY, 3: cycles from in_valid being sampled to the matching product on q; must be >= 0 (0 = same cycle).
- CNT_WIDTH, clog2(COUNT+1): width of out_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset.
- in_valid  in  1  high in the cycle the operands are presented to the multiplier stage.
- q  in  PROD_WIDTH  product from the multiplier; meaningful IN_LATENCY cycles after in_valid.
- flush  in  1  one-cycle pulse: close the current partial group early.
- out_valid  out  1  out_sum/out_count hold a completed group.
- out_ready  in  1  sink accepts the output this cycle.
- out_sum  out  ACC_WIDTH  completed group sum.
- out_count  out  CNT_WIDTH  number of products in out_sum (1..COUNT).
- busy  out  1  partial group in progress or valid beats in flight.
- overrun  out  1  sticky: a completed group was dropped.

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.

Behaviour:
- Reset values:
  - valid delay line cleared; accumulator 0; beat counter 0.
  - out_valid 0, out_sum 0, out_count 0, overrun 0, busy 0.
- Alignment:
  - beat = in_valid delayed by IN_LATENCY registers (combinational when IN_LATENCY = 0).
  - q is sampled only when beat = 1; q is ignored otherwise.
- Accumulation:
  - On each beat, next = acc + zero-extend(q) and cnt increments.
  - On the COUNT-th beat, the group completes with sum = acc + q and count = COUNT. acc and cnt return to 0 in the same cycle, so back-to-back groups need no gap.
- Flush:
  - flush with cnt > 0 and no beat: the group completes with sum = acc and count = cnt.
  - flush together with a beat: that beat is included; the group completes with acc + q and cnt + 1.
  - flush with cnt = 0 and no beat: no effect.
  - Beats still in the delay line are not flushed; they start the next group.
- Output register, two states:
  - EMPTY -> FULL on completion: load out_sum/out_count, set out_valid.
  - FULL -> EMPTY when out_ready = 1 and there is no completion that cycle.
  - FULL with out_ready = 1 and a completion in the same cycle: load the new group, stay FULL.
  - FULL with out_ready = 0 and a completion: keep the held group, drop the new one, set overrun.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - Latency: last aligned beat at cycle t -> out_valid = 1 at cycle t+1.
  - Outputs are stable while out_valid & !out_ready.
- busy = (cnt != 0) | any delay-line bit set.
- overrun clears only on rst.
- rst mid-group or mid-hold discards everything, including in-flight beats; the first group after reset counts from zero.

Decomposition:
- Shared package holds:
  - output-state enum (OUT_EMPTY, OUT_FULL);
  - a clog2 helper function;
  - default widths (PROD_WIDTH = 8, ACC_WIDTH = 10).
- One sub-module: valid_delay.
  - Parameter DEPTH; ports clk, rst, d, q.
  - Shift register with synchronous clear; the DEPTH = 0 case is a passthrough.
  - Reusable for any other stage whose pipeline depth is retimed.

Test Plan:
- IN_LATENCY = 3, out_ready = 1. Four in_valid pulses on consecutive cycles; q = 225 on each aligned beat (15*15). Required: out_valid one cycle after the 4th beat, out_sum = 900, out_count = 4, overflow-free.
- Back-to-back groups: 8 consecutive beats with q = 1,2,...,8. Required: sums 10 then 26, each out_count = 4, no idle cycle between groups.
- Flush: 3 beats of q = 6 (3*2), then flush alone. Required: out_sum = 18, out_count = 3. Then flush coincident with a single beat q = 9: out_sum = 9, out_count = 1.
- Backpressure: out_ready = 0, group A = 4 x 1 completes and is held; group B = 4 x 2 completes. Required: out_sum stays 4 and overrun = 1. Raise out_ready: A transfers, out_valid drops, and B is never seen.
- Simultaneous drain and completion: out_ready pulses in the same cycle group B completes. Required: A transfers, B loaded, out_valid remains 1, overrun = 0.
- Reset: assert rst after 2 beats with 2 beats still in flight. Required: next cycle out_valid = 0, busy = 0, overrun = 0. A fresh 4 x 3 group then yields 12.
